// File: rtl/apb_timer_pkg.sv
// Shared constants for the APB timer: register offsets, CTRL/STATUS bit
// positions, the read wait-state FSM encoding and a byte-lane merge helper.
package apb_timer_pkg;

  localparam logic [11:0] REG_CTRL     = 12'h000;
  localparam logic [11:0] REG_PRESCALE = 12'h004;
  localparam logic [11:0] REG_LOAD     = 12'h008;
  localparam logic [11:0] REG_COUNT    = 12'h00C;
  localparam logic [11:0] REG_CMP      = 12'h010;
  localparam logic [11:0] REG_STATUS   = 12'h014;

  localparam int unsigned CTRL_EN          = 0;
  localparam int unsigned CTRL_AUTO_RELOAD = 1;
  localparam int unsigned CTRL_OVF_IE      = 2;
  localparam int unsigned CTRL_CMP_IE      = 3;

  localparam int unsigned STAT_OVF = 0;
  localparam int unsigned STAT_CMP = 1;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_WAIT = 1'b1
  } rd_state_e;

  // Replace the byte lanes of old_v selected by strb with those of new_v.
  function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
      else         res[8*i +: 8] = old_v[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/apb_timer_cnt.sv
// Prescaler and down-counter core: generates ticks, counts down, reloads or
// stops at zero, and emits single-cycle overflow / compare set pulses.
module apb_timer_cnt
  import apb_timer_pkg::*;
#(
  parameter int unsigned timer_width = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en_i,
  input  logic                   auto_reload_i,
  input  logic                   start_i,
  input  logic [15:0]            prescale_i,
  input  logic [timer_width-1:0] load_i,
  input  logic [timer_width-1:0] cmp_i,
  output logic [timer_width-1:0] count_o,
  output logic                   ovf_set_o,
  output logic                   cmp_set_o,
  output logic                   oneshot_clr_o
);

  localparam logic [timer_width-1:0] CNT_ONE = timer_width'(1);

  logic [15:0]            pcnt_q, pcnt_d;
  logic [timer_width-1:0] count_q, count_d, count_dec_s;
  logic                   tick_s;

  assign tick_s      = en_i & (pcnt_q == prescale_i);
  assign count_dec_s = count_q - CNT_ONE;
  assign count_o     = count_q;

  // Next-state for prescaler and counter; start only occurs while disabled
  always_comb begin
    pcnt_d        = pcnt_q;
    count_d       = count_q;
    ovf_set_o     = 1'b0;
    cmp_set_o     = 1'b0;
    oneshot_clr_o = 1'b0;
    if (start_i) begin
      pcnt_d  = 16'd0;
      count_d = load_i;
    end else if (tick_s) begin
      pcnt_d = 16'd0;
      if (count_q != '0) begin
        count_d   = count_dec_s;
        cmp_set_o = (count_dec_s == cmp_i);
      end else begin
        ovf_set_o = 1'b1;
        if (auto_reload_i) begin
          count_d = load_i;
        end else begin
          count_d       = count_q;
          oneshot_clr_o = 1'b1;
        end
      end
    end else if (en_i) begin
      pcnt_d = pcnt_q + 16'd1;
    end else begin
      pcnt_d = pcnt_q;
    end
  end

  // Counter state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q  <= 16'd0;
      count_q <= '0;
    end else begin
      pcnt_q  <= pcnt_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/apb_timer.sv
// APB timer top: register file, address decode / error response, W1C status,
// optional read wait state and the registered interrupt output.
module apb_timer
  import apb_timer_pkg::*;
#(
  parameter int unsigned timer_width = 32,
  parameter int unsigned read_wait   = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] paddr,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [2:0]  pprot,
  input  logic [3:0]  pstrb,
  input  logic [31:0] pwdata,
  output logic        pready,
  output logic        pslverr,
  output logic [31:0] prdata,
  output logic        irq
);

  logic                   access_s, mapped_s, err_s, wr_s;
  logic [11:0]            offs_s;
  logic [31:0]            rdata_s, prescale_m_s, load_m_s, cmp_m_s;
  logic                   wr_ctrl_s, wr_prescale_s, wr_load_s, wr_cmp_s, wr_status_s;
  logic                   start_s, ovf_set_s, cmp_set_s, oneshot_clr_s;
  logic [1:0]             clr_s;
  logic [3:0]             ctrl_q, ctrl_d;
  logic [15:0]            prescale_q, prescale_d;
  logic [timer_width-1:0] load_q, load_d, cmp_q, cmp_d, count_s;
  logic                   ovf_q, ovf_d, cmpf_q, cmpf_d, irq_q, irq_d;
  logic                   unused_s;

  assign access_s = psel & penable;
  assign offs_s   = {paddr[11:2], 2'b00};

  // Address decode
  always_comb begin
    case (offs_s)
      REG_CTRL, REG_PRESCALE, REG_LOAD,
      REG_COUNT, REG_CMP, REG_STATUS: mapped_s = 1'b1;
      default:                        mapped_s = 1'b0;
    endcase
  end

  assign err_s         = ~mapped_s | (pwrite & (offs_s == REG_COUNT));
  assign wr_s          = access_s & pwrite & ~err_s;
  assign wr_ctrl_s     = wr_s & (offs_s == REG_CTRL) & pstrb[0];
  assign wr_prescale_s = wr_s & (offs_s == REG_PRESCALE);
  assign wr_load_s     = wr_s & (offs_s == REG_LOAD);
  assign wr_cmp_s      = wr_s & (offs_s == REG_CMP);
  assign wr_status_s   = wr_s & (offs_s == REG_STATUS) & pstrb[0];

  assign prescale_m_s = apply_strb(32'(prescale_q), pwdata, pstrb);
  assign load_m_s     = apply_strb(32'(load_q), pwdata, pstrb);
  assign cmp_m_s      = apply_strb(32'(cmp_q), pwdata, pstrb);
  assign start_s      = wr_ctrl_s & ~ctrl_q[CTRL_EN] & pwdata[CTRL_EN];
  assign clr_s        = wr_status_s ? pwdata[1:0] : 2'b00;
  assign unused_s     = ^{pprot, paddr[31:12], paddr[1:0],
                          prescale_m_s[31:16], load_m_s, cmp_m_s};

  // The counter sees the pre-write CTRL value; a CTRL write lands next cycle
  apb_timer_cnt #(.timer_width(timer_width)) u_cnt (
    .clk           (clk),
    .rst_n         (rst_n),
    .en_i          (ctrl_q[CTRL_EN]),
    .auto_reload_i (ctrl_q[CTRL_AUTO_RELOAD]),
    .start_i       (start_s),
    .prescale_i    (prescale_q),
    .load_i        (load_q),
    .cmp_i         (cmp_q),
    .count_o       (count_s),
    .ovf_set_o     (ovf_set_s),
    .cmp_set_o     (cmp_set_s),
    .oneshot_clr_o (oneshot_clr_s)
  );

  // Register next-state; a software CTRL write overrides the one-shot clear
  always_comb begin
    ctrl_d     = ctrl_q;
    prescale_d = prescale_q;
    load_d     = load_q;
    cmp_d      = cmp_q;
    if (wr_ctrl_s)          ctrl_d          = pwdata[3:0];
    else if (oneshot_clr_s) ctrl_d[CTRL_EN] = 1'b0;
    else                    ctrl_d          = ctrl_q;
    if (wr_prescale_s) prescale_d = prescale_m_s[15:0];
    else               prescale_d = prescale_q;
    if (wr_load_s) load_d = load_m_s[timer_width-1:0];
    else           load_d = load_q;
    if (wr_cmp_s) cmp_d = cmp_m_s[timer_width-1:0];
    else          cmp_d = cmp_q;
    ovf_d  = ovf_set_s | (ovf_q & ~clr_s[STAT_OVF]);
    cmpf_d = cmp_set_s | (cmpf_q & ~clr_s[STAT_CMP]);
    irq_d  = (ovf_q & ctrl_q[CTRL_OVF_IE]) | (cmpf_q & ctrl_q[CTRL_CMP_IE]);
  end

  // Register file, flags and interrupt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q     <= 4'd0;
      prescale_q <= 16'd0;
      load_q     <= '0;
      cmp_q      <= '0;
      ovf_q      <= 1'b0;
      cmpf_q     <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      prescale_q <= prescale_d;
      load_q     <= load_d;
      cmp_q      <= cmp_d;
      ovf_q      <= ovf_d;
      cmpf_q     <= cmpf_d;
      irq_q      <= irq_d;
    end
  end

  assign irq = irq_q;

  // Read data mux; unmapped offsets read as zero
  always_comb begin
    case (offs_s)
      REG_CTRL:     rdata_s = 32'(ctrl_q);
      REG_PRESCALE: rdata_s = 32'(prescale_q);
      REG_LOAD:     rdata_s = 32'(load_q);
      REG_COUNT:    rdata_s = 32'(count_s);
      REG_CMP:      rdata_s = 32'(cmp_q);
      REG_STATUS:   rdata_s = {30'd0, cmpf_q, ovf_q};
      default:      rdata_s = 32'd0;
    endcase
  end

  if (read_wait == 0) begin : g_rw0
    assign pready  = 1'b1;
    assign pslverr = access_s & err_s;
    assign prdata  = (access_s & ~pwrite) ? rdata_s : 32'd0;
  end else begin : g_rw1
    rd_state_e   state_q, state_d;
    logic [31:0] prdata_q, prdata_d;
    logic        rd_first_s;

    assign rd_first_s = access_s & ~pwrite & (state_q == RD_IDLE);

    // Read wait-state FSM: capture data in the first access cycle
    always_comb begin
      state_d  = state_q;
      prdata_d = prdata_q;
      case (state_q)
        RD_IDLE: begin
          if (rd_first_s) begin
            state_d  = RD_WAIT;
            prdata_d = rdata_s;
          end else begin
            state_d  = RD_IDLE;
            prdata_d = 32'd0;
          end
        end
        RD_WAIT: begin
          state_d  = RD_IDLE;
          prdata_d = 32'd0;
        end
        default: begin
          state_d  = RD_IDLE;
          prdata_d = 32'd0;
        end
      endcase
    end

    // Wait-state registers
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q  <= RD_IDLE;
        prdata_q <= 32'd0;
      end else begin
        state_q  <= state_d;
        prdata_q <= prdata_d;
      end
    end

    assign pready  = ~rd_first_s;
    assign pslverr = access_s & pready & err_s;
    assign prdata  = (access_s & ~pwrite & (state_q == RD_WAIT)) ? prdata_q : 32'd0;
  end

endmodule

// File: tb/tb_apb_timer.sv
// Scoreboard bench for apb_timer: a zero-wait instance checked against a
// behavioural timer model, plus a one-wait-state instance for read timing/reset.
module tb_apb_timer;

  localparam logic [11:0] A_CTRL = 12'h000, A_PRE = 12'h004, A_LOAD = 12'h008;
  localparam logic [11:0] A_COUNT = 12'h00C, A_CMP = 12'h010, A_STAT = 12'h014;

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [15:0] pre;
    logic [31:0] load;
    logic [31:0] cmp;
    logic [31:0] count;
    logic [15:0] pcnt;
    logic        ovf;
    logic        cmpf;
    logic        irq;
  } mstate_t;

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, psel, penable, pwrite, sel_w, done;
  logic [31:0] paddr, pwdata;
  logic [2:0]  pprot;
  logic [3:0]  pstrb;
  logic        psel0, psel1, pready0, pready1, pslverr0, pslverr1, irq0, irq1;
  logic [31:0] prdata0, prdata1;
  logic        pready_m, pslverr_m, acc_prev;
  logic [31:0] prdata_m;
  mstate_t     m;
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;

  assign psel0     = psel & ~sel_w;
  assign psel1     = psel & sel_w;
  assign pready_m  = sel_w ? pready1 : pready0;
  assign pslverr_m = sel_w ? pslverr1 : pslverr0;
  assign prdata_m  = sel_w ? prdata1 : prdata0;

  always #5 clk = ~clk;

  apb_timer #(.timer_width(32), .read_wait(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .paddr(paddr), .psel(psel0), .penable(penable),
    .pwrite(pwrite), .pprot(pprot), .pstrb(pstrb), .pwdata(pwdata),
    .pready(pready0), .pslverr(pslverr0), .prdata(prdata0), .irq(irq0));

  apb_timer #(.timer_width(32), .read_wait(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .paddr(paddr), .psel(psel1), .penable(penable),
    .pwrite(pwrite), .pprot(pprot), .pstrb(pstrb), .pwdata(pwdata),
    .pready(pready1), .pslverr(pslverr1), .prdata(prdata1), .irq(irq1));

  function automatic logic [31:0] lanes(logic [31:0] old_v, logic [31:0] new_v, logic [3:0] st);
    logic [31:0] mask;
    mask = {{8{st[3]}}, {8{st[2]}}, {8{st[1]}}, {8{st[0]}}};
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  function automatic logic model_err(logic [11:0] a, logic w);
    return !(a inside {A_CTRL, A_PRE, A_LOAD, A_COUNT, A_CMP, A_STAT}) || (w && a == A_COUNT);
  endfunction

  function automatic logic [31:0] model_read(mstate_t s, logic [11:0] a);
    case (a)
      A_CTRL:  return {28'd0, s.ctrl};
      A_PRE:   return {16'd0, s.pre};
      A_LOAD:  return s.load;
      A_COUNT: return s.count;
      A_CMP:   return s.cmp;
      A_STAT:  return {30'd0, s.cmpf, s.ovf};
      default: return 32'd0;
    endcase
  endfunction

  // One clock of timer behaviour from the register-level rules
  function automatic mstate_t model_step(mstate_t s, logic acc, logic w, logic [11:0] a,
                                         logic [31:0] d, logic [3:0] st);
    mstate_t n;
    logic ovf_set, cmp_set;
    n = s;
    ovf_set = 1'b0;
    cmp_set = 1'b0;
    n.irq = (s.ovf && s.ctrl[2]) || (s.cmpf && s.ctrl[3]);
    if (s.ctrl[0]) begin
      if (s.pcnt == s.pre) begin
        n.pcnt = 16'd0;
        if (s.count != 32'd0) begin
          n.count = s.count - 32'd1;
          cmp_set = (n.count == s.cmp);
        end else begin
          ovf_set = 1'b1;
          if (s.ctrl[1]) n.count = s.load;
          else           n.ctrl[0] = 1'b0;
        end
      end else begin
        n.pcnt = s.pcnt + 16'd1;
      end
    end
    if (acc && w && !model_err(a, w)) begin
      case (a)
        A_CTRL: if (st[0]) begin
          if (!s.ctrl[0] && d[0]) begin
            n.count = s.load;
            n.pcnt  = 16'd0;
          end
          n.ctrl = d[3:0];
        end
        A_PRE:  n.pre  = 16'(lanes({16'd0, s.pre}, d, st));
        A_LOAD: n.load = lanes(s.load, d, st);
        A_CMP:  n.cmp  = lanes(s.cmp, d, st);
        A_STAT: if (st[0]) begin
          if (d[0]) n.ovf  = 1'b0;
          if (d[1]) n.cmpf = 1'b0;
        end
        default: n = n;
      endcase
    end
    if (ovf_set) n.ovf  = 1'b1;
    if (cmp_set) n.cmpf = 1'b1;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= model_step(m, psel0 && penable, pwrite, {paddr[11:2], 2'b00}, pwdata, pstrb);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: reset values, irq, wait-state timing and scoreboard pops
  initial begin
    exp_t e;
    acc_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done) begin
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
      if (!rst_n) begin
        chk("rst_pready0", 32'(pready0), 32'd1);
        chk("rst_pready1", 32'(pready1), 32'd1);
        chk("rst_prdata1", prdata1, 32'd0);
        chk("rst_irq", {irq1, irq0}, 32'd0);
        acc_prev = 1'b0;
      end else begin
        chk("irq", 32'(irq0), 32'(m.irq));
        if (psel && penable) begin
          if (!acc_prev) chk("first_pready", 32'(pready_m), 32'(!(sel_w && !pwrite)));
          else           chk("wait_len", 32'(pready_m), 32'd1);
          if (pready_m) begin
            if (sb.size() == 0) begin
              chk("sb_underflow", 32'd1, 32'd0);
            end else begin
              e = sb.pop_front();
              chk("prdata", prdata_m, e.rd);
              chk("pslverr", 32'(pslverr_m), 32'(e.err));
            end
          end else begin
            chk("prdata_wait", prdata_m, 32'd0);
          end
        end
        acc_prev = psel && penable && !pready_m;
      end
    end
  end

  task automatic xfer(input logic w, input logic [11:0] off, input logic [31:0] data,
                      input logic [3:0] strb, input logic [31:0] exp1);
    exp_t e;
    @(posedge clk); #1;
    paddr   = {20'($urandom), off[11:2], 2'($urandom)};
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = w;
    pwdata  = data;
    pstrb   = strb;
    pprot   = 3'($urandom);
    @(posedge clk); #1;
    penable = 1'b1;
    e.err = model_err(off, w);
    if (w)          e.rd = 32'd0;
    else if (sel_w) e.rd = exp1;
    else            e.rd = model_read(m, off);
    sb.push_back(e);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (pready_m) break;
    end
    @(posedge clk); #1;
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
  endtask

  task automatic wr(input logic [11:0] off, input logic [31:0] data);
    xfer(1'b1, off, data, 4'hF, 32'd0);
  endtask

  task automatic rd(input logic [11:0] off);
    xfer(1'b0, off, 32'($urandom), 4'h0, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned op;
    logic [3:0]  st;
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; sel_w = 1'b0; done = 1'b0;
    paddr = 32'd0; pwdata = 32'd0; pstrb = 4'h0; pprot = 3'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int a = 0; a <= 24; a += 4) rd(12'(a));

    // auto-reload, prescale 3
    wr(A_PRE, 32'd3); wr(A_LOAD, 32'd2); wr(A_CTRL, 32'h3);
    repeat (10) begin rd(A_COUNT); rd(A_STAT); end

    // one-shot with overflow interrupt
    wr(A_CTRL, 32'h0); wr(A_STAT, 32'h3);
    wr(A_LOAD, 32'd1); wr(A_PRE, 32'd0); wr(A_CTRL, 32'h5);
    repeat (2) @(posedge clk);
    rd(A_CTRL); rd(A_COUNT); rd(A_STAT);
    wr(A_STAT, 32'h1); rd(A_STAT);

    // compare match with interrupt
    wr(A_CTRL, 32'h0); wr(A_CMP, 32'd5); wr(A_LOAD, 32'd9); wr(A_CTRL, 32'hB);
    repeat (6) rd(A_STAT);

    // W1C colliding with a fresh overflow set every cycle
    wr(A_CTRL, 32'h0); wr(A_LOAD, 32'd0); wr(A_CTRL, 32'h3);
    wr(A_STAT, 32'h1); rd(A_STAT);

    // byte strobes, COUNT write error
    wr(A_CTRL, 32'h0); wr(A_LOAD, 32'd0);
    xfer(1'b1, A_LOAD, 32'hAABB_CCDD, 4'b0101, 32'd0); rd(A_LOAD);
    xfer(1'b1, A_LOAD, 32'hFFFF_FFFF, 4'b0000, 32'd0); rd(A_LOAD);
    wr(A_COUNT, 32'h55); rd(A_COUNT);

    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 9);
      st = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      case (op)
        0: xfer(1'b1, A_CTRL, $urandom, st, 32'd0);
        1: xfer(1'b1, A_PRE, $urandom_range(0, 3), st, 32'd0);
        2: xfer(1'b1, A_LOAD, $urandom_range(0, 12), st, 32'd0);
        3: xfer(1'b1, A_CMP, $urandom_range(0, 12), st, 32'd0);
        4: xfer(1'b1, A_STAT, $urandom, st, 32'd0);
        5: xfer(1'b1, ($urandom_range(0, 1) == 0) ? A_COUNT :
                      12'(32'h18 + 32'd4 * $urandom_range(0, 1000)), $urandom, st, 32'd0);
        6: rd(12'(32'd4 * $urandom_range(0, 7)));
        7: repeat ($urandom_range(1, 6)) @(posedge clk);
        default: rd(($urandom_range(0, 1) == 0) ? A_COUNT : A_STAT);
      endcase
    end

    // one-wait-state instance
    sel_w = 1'b1;
    xfer(1'b1, A_LOAD, 32'h1234_5678, 4'hF, 32'd0);
    xfer(1'b0, A_LOAD, 32'd0, 4'h0, 32'h1234_5678);
    xfer(1'b0, 12'h018, 32'd0, 4'h0, 32'd0);
    xfer(1'b1, A_COUNT, 32'd7, 4'hF, 32'd0);
    xfer(1'b0, A_COUNT, 32'd0, 4'h0, 32'd0);

    // reset in the middle of a read wait state
    @(posedge clk); #1;
    paddr = {20'd0, A_LOAD}; psel = 1'b1; penable = 1'b0; pwrite = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk); #2;
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    xfer(1'b0, A_LOAD, 32'd0, 4'h0, 32'd0);
    sel_w = 1'b0;
    for (int a = 0; a <= 20; a += 4) rd(12'(a));

    repeat (2) @(posedge clk);
    done = 1'b1;
  end

endmodule
